store_drain_scheduler: RTL and testbench

Sits between the load/store buffer and the memory controller's LSB port; it schedules that port. Committed stores are queued in a small FIFO and drained to memory in order. Loads are given priority over queued stores unless a store hazard exists. Load results are returned with unused upper bytes zeroed.

---
 rtl/store_drain_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_store_drain_scheduler.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_drain_scheduler.sv
// Store drain scheduler: queues committed stores, arbitrates a single memory
// controller port between the pending load and in-order store drain.
module store_drain_scheduler #(
  parameter int DEPTH     = 4,
  parameter int PTR_WIDTH = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        st_req_en,
  input  logic [31:0] st_addr,
  input  logic [1:0]  st_width,
  input  logic [31:0] st_data,
  output logic        st_ready,
  input  logic        ld_req_en,
  input  logic [31:0] ld_addr,
  input  logic [1:0]  ld_width,
  output logic        ld_ready,
  output logic        ld_result_en,
  output logic [31:0] ld_result_data,
  output logic        buf_empty,
  output logic        mc_query_en,
  output logic        mc_query_type,
  output logic [31:0] mc_query_addr,
  output logic [1:0]  mc_data_width,
  output logic [31:0] mc_query_data,
  input  logic        mc_result_en,
  input  logic [31:0] mc_result_data
);

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, STORE_WAIT} state_e;

  localparam logic [PTR_WIDTH:0]   FULL    = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0]   CNT_ONE = (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE = PTR_WIDTH'(1);

  state_e               state_q, state_d;
  logic [PTR_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_WIDTH:0]   count_q, count_d;
  logic [31:0]          fifo_addr_q  [DEPTH];
  logic [31:0]          fifo_data_q  [DEPTH];
  logic [1:0]           fifo_width_q [DEPTH];

  logic        ld_pending_q, ld_pending_d;
  logic [31:0] ld_addr_q, ld_addr_d;
  logic [1:0]  ld_width_q, ld_width_d;
  logic        ld_result_en_q, ld_result_en_d;
  logic [31:0] ld_result_data_q, ld_result_data_d;
  logic        mc_type_q, mc_type_d;
  logic [31:0] mc_addr_q, mc_addr_d;
  logic [1:0]  mc_width_q, mc_width_d;
  logic [31:0] mc_data_q, mc_data_d;

  logic st_accept, ld_accept, deq, ld_blocked;

  // Width code 3 is folded into a word access so it never reaches the port.
  function automatic logic [1:0] norm_width(input logic [1:0] w);
    return (w == 2'd3) ? 2'd2 : w;
  endfunction

  function automatic logic [31:0] mask_data(input logic [31:0] d, input logic [1:0] w);
    case (w)
      2'd0:    return {24'd0, d[7:0]};
      2'd1:    return {16'd0, d[15:0]};
      default: return d;
    endcase
  endfunction

  assign st_ready       = (count_q != FULL);
  assign ld_ready       = !ld_pending_q;
  assign buf_empty      = (count_q == '0) && (state_q == IDLE);
  assign mc_query_en    = (state_q != IDLE) && !mc_result_en;
  assign mc_query_type  = mc_type_q;
  assign mc_query_addr  = mc_addr_q;
  assign mc_data_width  = mc_width_q;
  assign mc_query_data  = mc_data_q;
  assign ld_result_en   = ld_result_en_q;
  assign ld_result_data = ld_result_data_q;

  assign st_accept = st_req_en && st_ready;
  assign ld_accept = ld_req_en && ld_ready;

  // A slot is live when its distance from head is below count; the two
  // MMIO words are ordered against every outstanding store.
  always_comb begin
    ld_blocked = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (({1'b0, PTR_WIDTH'(i) - head_q} < count_q) &&
          (fifo_addr_q[i][31:2] == ld_addr_q[31:2]))
        ld_blocked = 1'b1;
    end
    if (((ld_addr_q == 32'h0003_0000) || (ld_addr_q == 32'h0003_0004)) && (count_q != '0))
      ld_blocked = 1'b1;
  end

  always_comb begin
    state_d          = state_q;
    head_d           = head_q;
    tail_d           = tail_q;
    count_d          = count_q;
    ld_pending_d     = ld_pending_q;
    ld_addr_d        = ld_addr_q;
    ld_width_d       = ld_width_q;
    ld_result_en_d   = 1'b0;
    ld_result_data_d = ld_result_data_q;
    mc_type_d        = mc_type_q;
    mc_addr_d        = mc_addr_q;
    mc_width_d       = mc_width_q;
    mc_data_d        = mc_data_q;
    deq              = 1'b0;

    case (state_q)
      IDLE: begin
        if ((count_q == FULL) || ((count_q != '0) && !(ld_pending_q && !ld_blocked))) begin
          mc_type_d  = 1'b1;
          mc_addr_d  = fifo_addr_q[head_q];
          mc_width_d = fifo_width_q[head_q];
          mc_data_d  = fifo_data_q[head_q];
          state_d    = STORE_WAIT;
        end else if (ld_pending_q && !ld_blocked) begin
          mc_type_d  = 1'b0;
          mc_addr_d  = ld_addr_q;
          mc_width_d = ld_width_q;
          mc_data_d  = '0;
          state_d    = LOAD_WAIT;
        end
      end
      LOAD_WAIT: begin
        if (mc_result_en) begin
          ld_result_en_d   = 1'b1;
          ld_result_data_d = mask_data(mc_result_data, ld_width_q);
          ld_pending_d     = 1'b0;
          state_d          = IDLE;
        end
      end
      STORE_WAIT: begin
        if (mc_result_en) begin
          deq     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (ld_accept) begin
      ld_pending_d = 1'b1;
      ld_addr_d    = ld_addr;
      ld_width_d   = norm_width(ld_width);
    end
    if (st_accept) tail_d = tail_q + PTR_ONE;
    if (deq)       head_d = head_q + PTR_ONE;
    case ({st_accept, deq})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control and port-visible registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q          <= IDLE;
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      ld_pending_q     <= 1'b0;
      ld_addr_q        <= '0;
      ld_width_q       <= '0;
      ld_result_en_q   <= 1'b0;
      ld_result_data_q <= '0;
      mc_type_q        <= 1'b0;
      mc_addr_q        <= '0;
      mc_width_q       <= '0;
      mc_data_q        <= '0;
    end else if (rdy_in) begin
      state_q          <= state_d;
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      ld_pending_q     <= ld_pending_d;
      ld_addr_q        <= ld_addr_d;
      ld_width_q       <= ld_width_d;
      ld_result_en_q   <= ld_result_en_d;
      ld_result_data_q <= ld_result_data_d;
      mc_type_q        <= mc_type_d;
      mc_addr_q        <= mc_addr_d;
      mc_width_q       <= mc_width_d;
      mc_data_q        <= mc_data_d;
    end
  end

  // Store payload storage; only slots between head and tail are meaningful
  always_ff @(posedge clk_in) begin
    if (rdy_in && !rst_in && st_accept) begin
      fifo_addr_q[tail_q]  <= st_addr;
      fifo_data_q[tail_q]  <= st_data;
      fifo_width_q[tail_q] <= norm_width(st_width);
    end
  end

endmodule

// File: tb/tb_store_drain_scheduler.sv
// Bench for store_drain_scheduler: directed sequences and a load-mask table,
// then random traffic checked against a queue-based scheduling model.
module tb_store_drain_scheduler;
  localparam int DEPTH = 4;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1, rdy_in = 1'b1;
  logic        st_req_en = 1'b0, ld_req_en = 1'b0;
  logic [31:0] st_addr = '0, st_data = '0, ld_addr = '0;
  logic [1:0]  st_width = '0, ld_width = '0;
  logic        st_ready, ld_ready, ld_result_en, buf_empty;
  logic [31:0] ld_result_data, mc_query_addr, mc_query_data;
  logic        mc_query_en, mc_query_type;
  logic [1:0]  mc_data_width;
  logic        mc_result_en = 1'b0;
  logic [31:0] mc_result_data = '0;

  always #5 clk_in = ~clk_in;

  store_drain_scheduler #(.DEPTH(DEPTH), .PTR_WIDTH(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .st_req_en(st_req_en), .st_addr(st_addr), .st_width(st_width), .st_data(st_data),
    .st_ready(st_ready),
    .ld_req_en(ld_req_en), .ld_addr(ld_addr), .ld_width(ld_width), .ld_ready(ld_ready),
    .ld_result_en(ld_result_en), .ld_result_data(ld_result_data), .buf_empty(buf_empty),
    .mc_query_en(mc_query_en), .mc_query_type(mc_query_type), .mc_query_addr(mc_query_addr),
    .mc_data_width(mc_data_width), .mc_query_data(mc_query_data),
    .mc_result_en(mc_result_en), .mc_result_data(mc_result_data)
  );

  typedef struct { logic [31:0] addr; logic [1:0] width; logic [31:0] data; } st_t;
  typedef struct { logic [31:0] addr; logic [1:0] width; logic [31:0] mc; logic [1:0] exp_w; logic [31:0] exp_d; } ldvec_t;

  st_t         st_q[$];
  bit          m_pend, m_busy, m_wr, m_res_en, m_rst_seen, m_consumed, auto_ctrl;
  logic [31:0] m_ld_addr, m_addr, m_data, m_res_data;
  logic [1:0]  m_ld_width, m_width;
  int          checks = 0, passes = 0, lat = 2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
  endtask

  function automatic logic [1:0] nw(input logic [1:0] w);
    return (w == 2'd3) ? 2'd2 : w;
  endfunction

  function automatic logic [31:0] lmask(input logic [31:0] d, input logic [1:0] w);
    if (w == 2'd0) return d & 32'h0000_00FF;
    if (w == 2'd1) return d & 32'h0000_FFFF;
    return d;
  endfunction

  function automatic bit blocked();
    foreach (st_q[i]) if (st_q[i].addr[31:2] == m_ld_addr[31:2]) return 1'b1;
    if ((m_ld_addr == 32'h30000 || m_ld_addr == 32'h30004) && st_q.size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic issue_wr();
    m_busy = 1; m_wr = 1;
    m_addr = st_q[0].addr; m_width = st_q[0].width; m_data = st_q[0].data;
  endtask

  task automatic issue_rd();
    m_busy = 1; m_wr = 0; m_addr = m_ld_addr; m_width = m_ld_width;
  endtask

  // Advance the model by one clock edge using the inputs about to be sampled.
  task automatic model_edge();
    bit take_st, take_ld;
    m_consumed = 0;
    m_rst_seen = rst_in;
    if (rst_in) begin
      st_q.delete(); m_pend = 0; m_busy = 0; m_res_en = 0; m_res_data = '0;
      return;
    end
    if (!rdy_in) return;
    take_st = st_req_en && (st_q.size() != DEPTH);
    take_ld = ld_req_en && !m_pend;
    m_res_en = 0;
    if (m_busy) begin
      if (mc_result_en) begin
        m_consumed = 1; m_busy = 0;
        if (m_wr) void'(st_q.pop_front());
        else begin m_res_en = 1; m_res_data = lmask(mc_result_data, m_ld_width); m_pend = 0; end
      end
    end else if (st_q.size() == DEPTH) issue_wr();
    else if (m_pend && !blocked()) issue_rd();
    else if (st_q.size() != 0) issue_wr();
    if (take_st) st_q.push_back('{addr: st_addr, width: nw(st_width), data: st_data});
    if (take_ld) begin m_pend = 1; m_ld_addr = ld_addr; m_ld_width = nw(ld_width); end
  endtask

  task automatic model_check();
    chk("mc_query_en", mc_query_en, m_busy && !mc_result_en);
    chk("st_ready", st_ready, st_q.size() != DEPTH);
    chk("ld_ready", ld_ready, !m_pend);
    chk("buf_empty", buf_empty, st_q.size() == 0 && !m_busy);
    chk("ld_result_en", ld_result_en, m_res_en);
    if (m_res_en) chk("ld_result_data", ld_result_data, m_res_data);
    if (m_busy) begin
      chk("mc_query_type", mc_query_type, m_wr);
      chk("mc_query_addr", mc_query_addr, m_addr);
      chk("mc_data_width", mc_data_width, m_width);
      if (m_wr) chk("mc_query_data", mc_query_data, m_data);
    end
  endtask

  task automatic drive_ctrl();
    if (m_rst_seen) begin mc_result_en = 0; lat = 2; end
    else if (mc_result_en) begin if (m_consumed) mc_result_en = 0; end
    else if (m_busy) begin
      if (lat == 0) begin
        mc_result_en = 1; mc_result_data = $urandom; lat = $urandom_range(1, 4);
      end else lat--;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk_in);
    #1;
    model_check();
    if (auto_ctrl) drive_ctrl();
  endtask

  task automatic complete(input logic [31:0] d);
    mc_result_data = d; mc_result_en = 1; tick(); mc_result_en = 0;
  endtask

  task automatic do_reset();
    rst_in = 1; tick(); tick(); rst_in = 0;
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 5))
      0: return 32'h2000;
      1: return 32'h2002;
      2: return 32'h2004;
      3: return 32'h30000;
      4: return 32'h30004;
      default: return $urandom;
    endcase
  endfunction

  ldvec_t vecs[4];

  initial begin
    vecs[0] = '{addr: 32'h100, width: 2'd0, mc: 32'hAABBCCDD, exp_w: 2'd0, exp_d: 32'h000000DD};
    vecs[1] = '{addr: 32'h104, width: 2'd1, mc: 32'h12345678, exp_w: 2'd1, exp_d: 32'h00005678};
    vecs[2] = '{addr: 32'h108, width: 2'd2, mc: 32'hCAFEF00D, exp_w: 2'd2, exp_d: 32'hCAFEF00D};
    vecs[3] = '{addr: 32'h10C, width: 2'd3, mc: 32'h87654321, exp_w: 2'd2, exp_d: 32'h87654321};
    auto_ctrl = 0;

    // Reset state
    do_reset();
    chk("rst st_ready", st_ready, 1);
    chk("rst ld_ready", ld_ready, 1);
    chk("rst buf_empty", buf_empty, 1);
    chk("rst mc_query_en", mc_query_en, 0);
    chk("rst mc_query_addr", mc_query_addr, 0);
    chk("rst ld_result_data", ld_result_data, 0);

    // Basic store
    st_req_en = 1; st_addr = 32'h1000; st_width = 2; st_data = 32'hDEADBEEF; tick(); st_req_en = 0;
    tick();
    chk("basic en", mc_query_en, 1);
    chk("basic type", mc_query_type, 1);
    chk("basic addr", mc_query_addr, 32'h1000);
    chk("basic width", mc_data_width, 2);
    chk("basic data", mc_query_data, 32'hDEADBEEF);
    complete(0);
    chk("basic buf_empty", buf_empty, 1);

    // Load bypass
    st_req_en = 1; st_addr = 32'h2000; st_width = 2; st_data = 32'h11111111;
    ld_req_en = 1; ld_addr = 32'h3000; ld_width = 0; tick();
    ld_req_en = 0; st_addr = 32'h2004; st_data = 32'h22222222; tick(); st_req_en = 0;
    chk("bypass type", mc_query_type, 0);
    chk("bypass addr", mc_query_addr, 32'h3000);
    complete(32'hAABBCCDD);
    chk("bypass res_en", ld_result_en, 1);
    chk("bypass res", ld_result_data, 32'h000000DD);
    chk("bypass ld_ready", ld_ready, 1);
    tick();
    chk("bypass st0 addr", mc_query_addr, 32'h2000);
    complete(0); tick();
    chk("bypass st1 addr", mc_query_addr, 32'h2004);
    chk("bypass st1 data", mc_query_data, 32'h22222222);
    complete(0);

    // RAW hazard
    st_req_en = 1; st_addr = 32'h2002; st_width = 1; st_data = 32'hBEEF;
    ld_req_en = 1; ld_addr = 32'h2000; ld_width = 2; tick(); st_req_en = 0; ld_req_en = 0;
    tick();
    chk("raw first type", mc_query_type, 1);
    chk("raw first addr", mc_query_addr, 32'h2002);
    tick();
    chk("raw still store", mc_query_type, 1);
    complete(0); tick();
    chk("raw load type", mc_query_type, 0);
    chk("raw load addr", mc_query_addr, 32'h2000);
    complete(32'h12345678);
    chk("raw res", ld_result_data, 32'h12345678);

    // Full FIFO with stalled controller
    for (int i = 0; i < 4; i++) begin
      st_req_en = 1; st_addr = 32'h4000 + 32'(16 * i); st_width = 2; st_data = 32'(i); tick();
    end
    st_req_en = 0;
    chk("full st_ready", st_ready, 0);
    ld_req_en = 1; ld_addr = 32'h5000; ld_width = 2; tick(); ld_req_en = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("full head held", mc_query_addr, 32'h4000);
    end
    complete(0); tick();
    chk("full load type", mc_query_type, 0);
    chk("full load addr", mc_query_addr, 32'h5000);
    complete(32'h55);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("full drain addr", mc_query_addr, 32'h4000 + 32'(16 * i));
      complete(0);
    end
    chk("full buf_empty", buf_empty, 1);

    // MMIO ordering
    st_req_en = 1; st_addr = 32'h30000; st_width = 2; st_data = 32'h1;
    ld_req_en = 1; ld_addr = 32'h30004; ld_width = 2; tick(); st_req_en = 0; ld_req_en = 0;
    tick();
    chk("io store first", mc_query_addr, 32'h30000);
    complete(0); tick();
    chk("io load type", mc_query_type, 0);
    chk("io load addr", mc_query_addr, 32'h30004);
    complete(32'h99);
    chk("io res", ld_result_data, 32'h99);

    // Load mask table
    foreach (vecs[i]) begin
      ld_req_en = 1; ld_addr = vecs[i].addr; ld_width = vecs[i].width; tick(); ld_req_en = 0;
      tick();
      chk("tbl type", mc_query_type, 0);
      chk("tbl addr", mc_query_addr, vecs[i].addr);
      chk("tbl width", mc_data_width, vecs[i].exp_w);
      complete(vecs[i].mc);
      chk("tbl res_en", ld_result_en, 1);
      chk("tbl res", ld_result_data, vecs[i].exp_d);
    end

    // Reset during STORE_WAIT with a hazard-blocked load pending
    st_req_en = 1; st_addr = 32'h6000; st_width = 2; st_data = 32'h66;
    ld_req_en = 1; ld_addr = 32'h6000; ld_width = 2; tick(); st_req_en = 0; ld_req_en = 0;
    tick();
    chk("rstw en", mc_query_en, 1);
    rst_in = 1; tick(); rst_in = 0;
    chk("rstw mc_query_en", mc_query_en, 0);
    chk("rstw st_ready", st_ready, 1);
    chk("rstw buf_empty", buf_empty, 1);
    chk("rstw ld_ready", ld_ready, 1);
    chk("rstw addr", mc_query_addr, 0);

    // Freeze mid-load
    ld_req_en = 1; ld_addr = 32'h7000; ld_width = 1; tick(); ld_req_en = 0;
    tick();
    chk("frz issued", mc_query_en, 1);
    rdy_in = 0;
    for (int k = 0; k < 5; k++) begin
      mc_result_data = 32'hFFFF1234; mc_result_en = (k == 2); tick();
      chk("frz no result", ld_result_en, 0);
      chk("frz addr", mc_query_addr, 32'h7000);
      chk("frz width", mc_data_width, 1);
      chk("frz type", mc_query_type, 0);
    end
    mc_result_en = 0; rdy_in = 1; tick();
    chk("frz still waiting", mc_query_en, 1);
    complete(32'hFFFF1234);
    chk("frz res", ld_result_data, 32'h00001234);

    // Random traffic against the model
    do_reset();
    auto_ctrl = 1;
    for (int c = 0; c < 4000; c++) begin
      st_req_en = ($urandom_range(0, 2) == 0);
      st_addr   = pick_addr(); st_width = 2'($urandom_range(0, 3)); st_data = $urandom;
      ld_req_en = ($urandom_range(0, 3) == 0);
      ld_addr   = pick_addr(); ld_width = 2'($urandom_range(0, 3));
      rdy_in    = ($urandom_range(0, 9) != 0);
      rst_in    = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
